// File: rtl/npu_pkg.sv
// Shared types and defaults for the NPU job scheduler slice.
package npu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        COMPUTE,
        DRAIN
    } sched_state_t;

    localparam int unsigned DEF_NUM_REQ = 2;
    localparam int unsigned DEF_TIMEOUT = 64;

    function automatic int unsigned npu_width(input int unsigned n);
        return 15 + n;
    endfunction

endpackage

// File: rtl/npu_rr_arbiter.sv
// Combinational round-robin pick; scanning starts just after last_grant.
module npu_rr_arbiter
    import npu_pkg::*;
#(
    parameter  int unsigned NUM_REQ = DEF_NUM_REQ,
    localparam int unsigned IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [IDW-1:0]     last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDW-1:0]     id,
    output logic               any_valid
);

    logic [IDW-1:0] cand;

    always_comb begin
        grant     = '0;
        id        = '0;
        any_valid = 1'b0;
        cand      = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = IDW'((32'(last_grant) + k) % NUM_REQ);
            if (!any_valid && req_valid[cand]) begin
                any_valid   = 1'b1;
                grant[cand] = 1'b1;
                id          = cand;
            end
        end
    end

endmodule

// File: rtl/npu_job_scheduler.sv
// Job front-end for the systolic datapath: arbitrate, launch, wait for PDONE,
// then drain the result FIFO onto a tagged valid/ready stream.
module npu_job_scheduler
    import npu_pkg::*;
#(
    parameter  int unsigned N             = 2,
    parameter  int unsigned NUM_REQ       = DEF_NUM_REQ,
    parameter  int unsigned WORDS_PER_JOB = 2 * N,
    parameter  int unsigned TIMEOUT       = DEF_TIMEOUT,
    localparam int unsigned WIDTH         = npu_width(N),
    localparam int unsigned IDW           = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_valid,
    output logic [NUM_REQ-1:0] req_ready,
    output logic [IDW-1:0]     grant_id,
    output logic               npu_start,
    input  logic               pdone,
    input  logic               fifo_empty,
    output logic               fifo_rd_en,
    input  logic [WIDTH-1:0]   fifo_dout,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [WIDTH-1:0]   res_data,
    output logic [IDW-1:0]     res_id,
    output logic               res_last,
    output logic               busy,
    output logic               err_timeout
);

    localparam int unsigned TW = $clog2(TIMEOUT);
    localparam int unsigned CW = $clog2(WORDS_PER_JOB + 1);

    sched_state_t       state, state_nx;
    logic [IDW-1:0]     last_grant;
    logic [TW-1:0]      timer;
    logic [CW-1:0]      reads_issued;
    logic [CW-1:0]      words_captured;
    logic               rd_pending;
    logic [NUM_REQ-1:0] arb_grant;
    logic [IDW-1:0]     arb_id;
    logic               arb_any;
    logic               timer_expired;
    logic               res_fire;

    assign timer_expired = (timer == TW'(TIMEOUT - 1));
    assign res_fire      = res_valid && res_ready;
    assign busy          = (state != IDLE);

    npu_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req_valid (req_valid),
        .last_grant(last_grant),
        .grant     (arb_grant),
        .id        (arb_id),
        .any_valid (arb_any)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        req_ready  = '0;
        npu_start  = 1'b0;
        fifo_rd_en = 1'b0;
        case (state)
            IDLE: begin
                req_ready = arb_grant;
                if (arb_any) state_nx = START;
            end
            START: begin
                npu_start = 1'b1;
                state_nx  = COMPUTE;
            end
            COMPUTE: begin
                if (pdone)              state_nx = DRAIN;
                else if (timer_expired) state_nx = IDLE;
            end
            DRAIN: begin
                // Only one word in flight: read, capture, hand over, then read again.
                fifo_rd_en = !fifo_empty && !rd_pending && !res_valid &&
                             (reads_issued < CW'(WORDS_PER_JOB));
                if (res_fire && res_last) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant     <= IDW'(NUM_REQ - 1);
            grant_id       <= '0;
            err_timeout    <= 1'b0;
            timer          <= '0;
            reads_issued   <= '0;
            words_captured <= '0;
            rd_pending     <= 1'b0;
            res_valid      <= 1'b0;
            res_data       <= '0;
            res_id         <= '0;
            res_last       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_any) begin
                        grant_id    <= arb_id;
                        last_grant  <= arb_id;
                        err_timeout <= 1'b0;
                    end
                end
                START: timer <= '0;
                COMPUTE: begin
                    if (pdone) begin
                        reads_issued   <= '0;
                        words_captured <= '0;
                        rd_pending     <= 1'b0;
                    end else if (timer_expired) begin
                        err_timeout <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                DRAIN: begin
                    rd_pending <= fifo_rd_en;
                    if (fifo_rd_en) reads_issued <= reads_issued + 1'b1;
                    if (rd_pending) begin
                        res_data       <= fifo_dout;
                        res_valid      <= 1'b1;
                        res_id         <= grant_id;
                        res_last       <= (words_captured == CW'(WORDS_PER_JOB - 1));
                        words_captured <= words_captured + 1'b1;
                    end else if (res_fire) begin
                        res_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
